// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: measurement engine for the HC-SR04 ultrasonic sensor.
//   Fires a trigger pulse, times the echo-high width and converts it to
//   whole centimetres. A held distance word, a 1-cycle valid strobe and a
//   broken flag are presented to the downstream bus slave.
// Ports:
//   clk        in   system clock
//   reset_l    in   asynchronous active-low reset
//   enable     in   1 = run periodic measurements (sampled only when idle)
//   echo       in   raw sensor echo, asynchronous to clk
//   trigger    out  sensor trigger pulse
//   dist_cm    out  last result in cm, 16'hFFFF = no echo / over-range
//   dist_valid out  1-cycle strobe when dist_cm/broken update
//   broken     out  1 = last measurement failed
//   busy       out  1 = a measurement cycle is in progress
module hcsr04_ranger #(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYCLES_PER_CM = 2900,
  parameter int RISE_TIMEOUT  = 1_500_000,
  parameter int MAX_CM        = 400,
  parameter int PERIOD_CYCLES = 3_000_000
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic [15:0] dist_cm,
  output logic        dist_valid,
  output logic        broken,
  output logic        busy
);

  localparam int CYC_MAX_A = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
  localparam int CYC_MAX   = (CYC_MAX_A > PERIOD_CYCLES) ? CYC_MAX_A : PERIOD_CYCLES;
  localparam int CYC_W     = $clog2(CYC_MAX) + 1;
  localparam int SUB_W     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_CM - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [15:0]      cm_q, cm_d;
  logic [15:0]      dist_cm_q, dist_cm_d;
  logic             broken_q, broken_d;
  logic             trigger_q, trigger_d;
  logic             dist_valid_q, dist_valid_d;
  logic             busy_q, busy_d;
  logic             echo_meta_q, echo_meta_d;
  logic             echo_s_q, echo_s_d;

  // Next-state, counter and output computation
  always_comb begin
    state_d      = state_q;
    cyc_d        = {CYC_W{1'b0}};
    sub_d        = sub_q;
    cm_d         = cm_q;
    dist_cm_d    = dist_cm_q;
    broken_d     = broken_q;
    echo_meta_d  = echo;
    echo_s_d     = echo_meta_q;

    case (state_q)
      IDLE: begin
        // A stuck-high echo keeps us parked: never fire into a busy sensor.
        if (enable && !echo_s_q) begin
          state_d = TRIG;
        end else begin
          state_d = IDLE;
        end
      end
      TRIG: begin
        if (cyc_q == CYC_W'(TRIG_CYCLES - 1)) begin
          state_d = WAIT_RISE;
        end else begin
          state_d = TRIG;
        end
      end
      WAIT_RISE: begin
        if (echo_s_q) begin
          // The cycle that sees the rise is already echo-high, so it is
          // counted here; this makes the result floor(W / CYCLES_PER_CM).
          state_d = MEASURE;
          if (SUB_LAST == {SUB_W{1'b0}}) begin
            sub_d = {SUB_W{1'b0}};
            cm_d  = 16'd1;
          end else begin
            sub_d = SUB_W'(1);
            cm_d  = 16'd0;
          end
        end else if (cyc_q == CYC_W'(RISE_TIMEOUT - 1)) begin
          state_d   = DONE;
          dist_cm_d = 16'hFFFF;
          broken_d  = 1'b1;
        end else begin
          state_d = WAIT_RISE;
        end
      end
      MEASURE: begin
        if (!echo_s_q) begin
          state_d   = DONE;
          dist_cm_d = cm_q;
          broken_d  = 1'b0;
        end else if (sub_q == SUB_LAST) begin
          // Wrapping sub would push cm past the legal maximum.
          if (cm_q == 16'(MAX_CM)) begin
            state_d   = DONE;
            dist_cm_d = 16'hFFFF;
            broken_d  = 1'b1;
          end else begin
            sub_d = {SUB_W{1'b0}};
            cm_d  = cm_q + 16'd1;
          end
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      DONE: begin
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (cyc_q == CYC_W'(PERIOD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          state_d = HOLDOFF;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // cyc restarts on every state change and only runs in timed states.
    if (state_d != state_q) begin
      cyc_d = {CYC_W{1'b0}};
    end else if ((state_q == TRIG) || (state_q == WAIT_RISE) || (state_q == HOLDOFF)) begin
      cyc_d = cyc_q + CYC_W'(1);
    end else begin
      cyc_d = {CYC_W{1'b0}};
    end

    // Outputs are registered from the next state so they align with it.
    trigger_d    = (state_d == TRIG);
    dist_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      cyc_q        <= {CYC_W{1'b0}};
      sub_q        <= {SUB_W{1'b0}};
      cm_q         <= 16'd0;
      dist_cm_q    <= 16'd0;
      broken_q     <= 1'b0;
      trigger_q    <= 1'b0;
      dist_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      echo_meta_q  <= 1'b0;
      echo_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      sub_q        <= sub_d;
      cm_q         <= cm_d;
      dist_cm_q    <= dist_cm_d;
      broken_q     <= broken_d;
      trigger_q    <= trigger_d;
      dist_valid_q <= dist_valid_d;
      busy_q       <= busy_d;
      echo_meta_q  <= echo_meta_d;
      echo_s_q     <= echo_s_d;
    end
  end

  assign trigger    = trigger_q;
  assign dist_cm    = dist_cm_q;
  assign dist_valid = dist_valid_q;
  assign broken     = broken_q;
  assign busy       = busy_q;

endmodule
